magic_ctrl: RTL
===============

Name: magic_ctrl

Overview:
Parametrised successor of the magic-ROM controller.
- Arbitrates N_SRC NMI request sources, asserts NMI and tracks magic-ROM mapping across entry, signature check, exit and remap traps.
- Hosts a generic NREG x 8-bit config register file on an I/O port.
- Sits between the cpu_bus interface and the memory mapper / machine-config consumers.

Parameters:
N_SRC, 2, number of NMI request sources (1..8); index 0 has highest priority.
NREG, 12, number of config registers (1..255).
CFG_RESET, 0, NREG*8-bit flat reset image; register i occupies bits [8i+7:8i].
CFG_PORT, 8'hFF, low address byte of the config I/O port.
NMI_VEC, 16'h0066, M1 address that maps the magic ROM.
EXIT_ADDR, 16'hF000, read address that exits magic mode.
REMAP_ADDR, 16'hF008, read address that unmaps and re-maps on the next M1.
SIG_OPCODE, 8'hEB, required first opcode of the magic ROM.

Ports:
clk28  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
bus  interface  -  cpu_bus (mreq, ioreq, m1, rd, wr, a[15:0], d[7:0])
n_int  input  1  current INT level
n_int_next  input  1  next-cycle INT level
src_req  input  N_SRC  NMI request per source, level
status_in  input  4  external status bits for the status byte
n_nmi  output  1  NMI to CPU, active low
magic_mode  output  1  magic session active
magic_map  output  1  magic ROM mapped
cause  output  3  index of the source that opened the current session
cfg  output  NREG*8  config register file, flat
cfg_wstb  output  NREG  one-cycle write strobe per register
d_out  output  8  read data
d_out_active  output  1  d_out drives the bus

Behaviour:
- Reset values:
  - n_nmi=1, magic_mode=1, magic_map=1, signature check armed. The design boots into the magic ROM.
  - cause=0, pending=0, cfg=CFG_RESET, cfg_wstb=0, d_out_active=0.
- INT edge = n_int==1 && n_int_next==0. Requests are sampled only on an INT edge.
- INT edge, some src_req bit set, magic_mode=0: n_nmi<=0, magic_mode<=1, cause<=lowest set index.
- INT edge, some src_req bit set, magic_mode=1: pending<=1, n_nmi unchanged, cause unchanged.
- Priority chain, one branch per cycle, in this order:
  - (1) Signature check, while armed. On the first mreq&&m1&&rd, latch match=(d==SIG_OPCODE). On the first cycle after that read ends, disarm. If match=0, clear magic_mode and magic_map. Branches 2-5 are blocked while armed.
  - (2) EXIT trap: mapped && mreq && rd && a==EXIT_ADDR && !map_next sets unmap_next and magic_mode<=0; pending<=0 in the same cycle.
  - (3) REMAP trap: mapped && mreq && rd && a==REMAP_ADDR sets unmap_next and map_next.
  - (4) unmap_next && !mreq: magic_map<=0, unmap_next<=0. Unmapping always waits for the current memory cycle to finish.
  - (5) Entry: magic_mode && m1 && mreq && (a==NMI_VEC || map_next). Sets n_nmi<=1, magic_map<=1, map_next<=0. Arms the signature check only when a==NMI_VEC.
- An INT edge in the same cycle as branch 2: the new request is evaluated against the pre-update magic_mode=1, so it sets pending.
- Config access: cs = magic_map && ioreq && a[7:0]==CFG_PORT; index = a[15:8].
  - Write with index<NREG: register updated from d and cfg_wstb[index] pulses for 1 cycle, both on the same edge.
  - Write with index>=NREG: ignored.
  - Writes repeat every cycle wr is held. The register holds its value; cfg_wstb stays high for as long as wr is held.
- Reads are registered with 1-cycle latency: d_out_active <= cs && rd && valid_index.
  - Index 8'hFF returns {pending, cause, status_in}.
- Asynchronous reset mid-session returns to the reset state immediately, including map=1 and the signature check armed.

Optional Feature:
MAGIC_CFG_READBACK_EN
- Defined: reads with index<NREG return cfg[index] with the same 1-cycle latency.
- Undefined: only index 8'hFF is readable; all other reads leave d_out_active=0.

Decomposition:
- Package magic_pkg: MAGIC_STATUS_IDX=8'hFF, default SIG/NMI_VEC/EXIT/REMAP constants, cause width localparam.
- Sub-module magic_cfg_regs: register file, write decode, strobes, readback mux. Parameters NREG and CFG_RESET.
- magic_ctrl keeps the mapping/NMI logic and instantiates magic_cfg_regs.

Test Plan:
- Boot, first M1 read d=8'hEB -> magic_map and magic_mode stay 1. Repeat with d=8'h00 -> both cleared one cycle after the read ends.
- magic_mode=0, src_req=2'b10, INT edge -> n_nmi=0, cause=1. Then M1 read at 16'h0066 -> n_nmi=1, magic_map=1.
- Mapped, read 16'hF000 during a long mreq -> magic_mode=0 immediately; magic_map drops only after mreq deasserts.
- Read 16'hF008, then M1 at 16'h1234 -> map drops after mreq, re-asserts on the 16'h1234 M1, signature check not armed.
- In session, src_req=2'b01 at INT edge -> pending=1, n_nmi stays 1. I/O read 16'hFFFF returns bit7=1. After EXIT, pending=0.
- OUT 16'h02FF with 8'h5A -> cfg[23:16]=8'h5A, cfg_wstb[2] high for the cycle wr is held. IN 16'h02FF returns 8'h5A only with readback enabled. OUT 16'h20FF (NREG=12) -> no change.

Source files
------------

// File: rtl/magic_pkg.sv
// Shared constants, types and helpers for the magic-ROM controller.
package magic_pkg;

  localparam logic [7:0]  MAGIC_STATUS_IDX = 8'hFF;
  localparam logic [7:0]  MAGIC_CFG_PORT   = 8'hFF;
  localparam logic [7:0]  MAGIC_SIG_OPCODE = 8'hEB;
  localparam logic [15:0] MAGIC_NMI_VEC    = 16'h0066;
  localparam logic [15:0] MAGIC_EXIT_ADDR  = 16'hF000;
  localparam logic [15:0] MAGIC_REMAP_ADDR = 16'hF008;

  localparam int CAUSE_W = 3;
  typedef logic [CAUSE_W-1:0] cause_t;

  // Signature check: armed until the first opcode fetch, then waits for it to end.
  typedef enum logic [1:0] {
    SIG_OFF   = 2'd0,
    SIG_ARMED = 2'd1,
    SIG_READ  = 2'd2
  } sig_state_t;

  function automatic cause_t lowest_set(input logic [7:0] req);
    cause_t idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = cause_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cpu_bus.sv
// CPU bus bundle seen by the magic-ROM controller.
interface cpu_bus;
  logic        mreq;
  logic        ioreq;
  logic        m1;
  logic        rd;
  logic        wr;
  logic [15:0] a;
  logic [7:0]  d;

  modport slave  (input  mreq, ioreq, m1, rd, wr, a, d);
  modport master (output mreq, ioreq, m1, rd, wr, a, d);
endinterface

// File: rtl/magic_cfg_regs.sv
// Generic NREG x 8-bit config register file with write strobes and registered reads.
// MAGIC_CFG_READBACK_EN: when defined, registers are readable as well as the status byte.
module magic_cfg_regs
  import magic_pkg::*;
#(
  parameter int                NREG      = 12,
  parameter logic [NREG*8-1:0] CFG_RESET = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cs_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [7:0]        idx_i,
  input  logic [7:0]        wdata_i,
  input  logic [7:0]        status_i,
  output logic [NREG*8-1:0] cfg_o,
  output logic [NREG-1:0]   wstb_o,
  output logic [7:0]        rdata_o,
  output logic              rdata_vld_o
);

  logic [NREG*8-1:0] cfg_q, cfg_d;
  logic [NREG-1:0]   wstb_q, wstb_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rvld_q, rvld_d;

  always_comb begin
    cfg_d  = cfg_q;
    wstb_d = '0;
    if (cs_i && wr_i) begin
      for (int i = 0; i < NREG; i++) begin
        if (idx_i == 8'(i)) begin
          cfg_d[i*8 +: 8] = wdata_i;
          wstb_d[i]       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rvld_d  = 1'b0;
    rdata_d = 8'h00;
    if (cs_i && rd_i) begin
      if (idx_i == MAGIC_STATUS_IDX) begin
        rvld_d  = 1'b1;
        rdata_d = status_i;
      end
`ifdef MAGIC_CFG_READBACK_EN
      else begin
        for (int i = 0; i < NREG; i++) begin
          if (idx_i == 8'(i)) begin
            rvld_d  = 1'b1;
            rdata_d = cfg_q[i*8 +: 8];
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q  <= CFG_RESET;
      wstb_q <= '0;
      rvld_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      wstb_q <= wstb_d;
      rvld_q <= rvld_d;
    end
  end

  // Read data is qualified by rvld_q, so it carries no reset.
  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
  end

  assign cfg_o       = cfg_q;
  assign wstb_o      = wstb_q;
  assign rdata_o     = rdata_q;
  assign rdata_vld_o = rvld_q;

endmodule

// File: rtl/magic_ctrl.sv
// Magic-ROM controller: NMI arbitration, magic ROM mapping traps and config register port.
// MAGIC_CFG_READBACK_EN (optional): enables readback of config registers through magic_cfg_regs.
module magic_ctrl
  import magic_pkg::*;
#(
  parameter int                N_SRC      = 2,
  parameter int                NREG       = 12,
  parameter logic [NREG*8-1:0] CFG_RESET  = '0,
  parameter logic [7:0]        CFG_PORT   = MAGIC_CFG_PORT,
  parameter logic [15:0]       NMI_VEC    = MAGIC_NMI_VEC,
  parameter logic [15:0]       EXIT_ADDR  = MAGIC_EXIT_ADDR,
  parameter logic [15:0]       REMAP_ADDR = MAGIC_REMAP_ADDR,
  parameter logic [7:0]        SIG_OPCODE = MAGIC_SIG_OPCODE
) (
  input  logic              clk28,
  input  logic              rst_n,
  cpu_bus.slave             bus,
  input  logic              n_int,
  input  logic              n_int_next,
  input  logic [N_SRC-1:0]  src_req,
  input  logic [3:0]        status_in,
  output logic              n_nmi,
  output logic              magic_mode,
  output logic              magic_map,
  output logic [2:0]        cause,
  output logic [NREG*8-1:0] cfg,
  output logic [NREG-1:0]   cfg_wstb,
  output logic [7:0]        d_out,
  output logic              d_out_active
);

  logic       n_nmi_q, n_nmi_d;
  logic       mode_q, mode_d;
  logic       map_q, map_d;
  cause_t     cause_q, cause_d;
  logic       pending_q, pending_d;
  logic       unmap_next_q, unmap_next_d;
  logic       map_next_q, map_next_d;
  logic       sig_match_q, sig_match_d;
  sig_state_t sig_q, sig_d;

  logic [7:0] req_ext;
  logic       int_edge;
  logic       fetch_rd;
  logic       exit_hit;
  logic       remap_hit;
  logic       entry_hit;

  assign req_ext   = 8'(src_req);
  assign int_edge  = n_int & ~n_int_next;
  assign fetch_rd  = bus.mreq & bus.m1 & bus.rd;
  assign exit_hit  = map_q & bus.mreq & bus.rd & (bus.a == EXIT_ADDR) & ~map_next_q;
  assign remap_hit = map_q & bus.mreq & bus.rd & (bus.a == REMAP_ADDR);
  assign entry_hit = mode_q & bus.m1 & bus.mreq & ((bus.a == NMI_VEC) | map_next_q);

  always_comb begin
    n_nmi_d      = n_nmi_q;
    mode_d       = mode_q;
    map_d        = map_q;
    cause_d      = cause_q;
    pending_d    = pending_q;
    unmap_next_d = unmap_next_q;
    map_next_d   = map_next_q;
    sig_match_d  = sig_match_q;
    sig_d        = sig_q;

    // Only one mapping branch acts per cycle; the signature check blocks all others.
    if (sig_q != SIG_OFF) begin
      case (sig_q)
        SIG_ARMED: begin
          if (fetch_rd) begin
            sig_d       = SIG_READ;
            sig_match_d = (bus.d == SIG_OPCODE);
          end
        end
        SIG_READ: begin
          if (!fetch_rd) begin
            sig_d = SIG_OFF;
            if (!sig_match_q) begin
              mode_d = 1'b0;
              map_d  = 1'b0;
            end
          end
        end
        default: sig_d = SIG_OFF;
      endcase
    end else if (exit_hit) begin
      unmap_next_d = 1'b1;
      mode_d       = 1'b0;
      pending_d    = 1'b0;
    end else if (remap_hit) begin
      unmap_next_d = 1'b1;
      map_next_d   = 1'b1;
    end else if (unmap_next_q && !bus.mreq) begin
      map_d        = 1'b0;
      unmap_next_d = 1'b0;
    end else if (entry_hit) begin
      n_nmi_d    = 1'b1;
      map_d      = 1'b1;
      map_next_d = 1'b0;
      if (bus.a == NMI_VEC) sig_d = SIG_ARMED;
    end

    // Evaluated against the registered mode, so it overrides a same-cycle exit.
    if (int_edge && (req_ext != 8'h00)) begin
      if (!mode_q) begin
        n_nmi_d = 1'b0;
        mode_d  = 1'b1;
        cause_d = lowest_set(req_ext);
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      n_nmi_q      <= 1'b1;
      mode_q       <= 1'b1;
      map_q        <= 1'b1;
      cause_q      <= '0;
      pending_q    <= 1'b0;
      unmap_next_q <= 1'b0;
      map_next_q   <= 1'b0;
      sig_match_q  <= 1'b0;
      sig_q        <= SIG_ARMED;
    end else begin
      n_nmi_q      <= n_nmi_d;
      mode_q       <= mode_d;
      map_q        <= map_d;
      cause_q      <= cause_d;
      pending_q    <= pending_d;
      unmap_next_q <= unmap_next_d;
      map_next_q   <= map_next_d;
      sig_match_q  <= sig_match_d;
      sig_q        <= sig_d;
    end
  end

  logic       cfg_cs;
  logic [7:0] status_byte;

  assign cfg_cs      = map_q & bus.ioreq & (bus.a[7:0] == CFG_PORT);
  assign status_byte = {pending_q, cause_q, status_in};

  magic_cfg_regs #(
    .NREG      (NREG),
    .CFG_RESET (CFG_RESET)
  ) u_cfg_regs (
    .clk_i       (clk28),
    .rst_ni      (rst_n),
    .cs_i        (cfg_cs),
    .wr_i        (bus.wr),
    .rd_i        (bus.rd),
    .idx_i       (bus.a[15:8]),
    .wdata_i     (bus.d),
    .status_i    (status_byte),
    .cfg_o       (cfg),
    .wstb_o      (cfg_wstb),
    .rdata_o     (d_out),
    .rdata_vld_o (d_out_active)
  );

  assign n_nmi      = n_nmi_q;
  assign magic_mode = mode_q;
  assign magic_map  = map_q;
  assign cause      = cause_q;

endmodule
